imm_gen_stage: RTL and testbench
================================

// Module: imm_gen_stage
// PURPOSE
//  Parametrised, registered immediate generator for the ID stage. Decodes all RV64I/RV32I immediate
//  formats (I, S, B, U, J, shift-amount) from the opcode and sign-extends them to XLEN.
//  Sits between IF/ID and the ID/EX register, with a valid/ready handshake and a 2-entry skid buffer.
//  Supports pipeline flush and keeps a saturating count of instructions with no legal immediate format.
// PARAMETERS
//  XLEN     64  data-path width; 32 or 64 only
//  CNT_W    16  width of illegal-instruction counter
// PORTS
//  clk            in   1     clock; all state updates on rising edge
//  reset          in   1     synchronous, active-high reset
//  flush          in   1     drop all buffered entries (branch mispredict / trap)
//  in_valid       in   1     instruction is valid this cycle
//  in_ready       out  1     stage can accept; transfer when in_valid && in_ready
//  instruction    in   32    raw instruction word
//  out_valid      out  1     imm_data/imm_fmt/illegal valid
//  out_ready      in   1     consumer accepts; transfer when out_valid && out_ready
//  imm_data       out  XLEN  sign-extended (or zero-extended shamt) immediate
//  imm_fmt        out  3     format code (package enum)
//  illegal        out  1     opcode not recognised
//  illegal_count  out  CNT_W saturating count of illegal entries accepted
// BEHAVIOUR
//  Decode (opcode = instruction[6:0]); sign bit is always instruction[31]:
//   0000011 load, 1100111 jalr, 0010011/0011011 op-imm -> I: instr[31:20]
//   op-imm funct3 001/101 -> SH: zero-ext instr[25:20] (XLEN=64, opcode 0010011), else instr[24:20]
//   0100011 store -> S: {instr[31:25],instr[11:7]}
//   1100011 branch -> B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
//   0110111 lui, 0010111 auipc -> U: {instr[31:12],12'b0}, sign-extended to XLEN
//   1101111 jal -> J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}
//   0110011/0111011 R-type -> fmt R, imm 0, illegal 0; any other opcode -> fmt NONE, imm 0, illegal 1
//  Buffering: main register M + skid register K, each {valid, imm, fmt, illegal}.
//   Latency 1 cycle: an accepted instruction appears on outputs the next cycle when M is empty or draining.
//   Outputs are driven from M only; in_ready = !K.valid (registered, no comb path from out_ready).
//   Accept while M is valid and not draining -> entry goes to K. When M drains, K moves into M first.
//   Order is strictly preserved; no entry is lost or duplicated under any valid/ready pattern.
//   Outputs hold stable while out_valid && !out_ready.
//  Flush: clears M.valid and K.valid next cycle. It wins over a same-cycle accept; that input is dropped
//   and is not counted. A same-cycle output transfer still completes from the consumer side.
//  illegal_count: +1 per accepted entry with illegal=1 (counted at accept); saturates at 2^CNT_W-1; not cleared by flush.
//  Reset: out_valid=0, K.valid=0, in_ready=1, imm_data=0, imm_fmt=NONE, illegal=0, illegal_count=0.
//   Reset mid-transfer discards all buffered entries; reset has priority over flush.
// STRUCTURE
//  imm_pkg: imm_fmt_e {NONE=0,I=1,S=2,B=3,U=4,J=5,SH=6,R=7}; OPC_* opcode constants; FUNCT3_SLL/SRL.
//  Sub-module imm_decode (combinational: instruction -> imm, fmt, illegal; parameter XLEN).
//  Top level holds the M/K skid logic and the counter.
// TESTING (XLEN=64, out_ready=1 unless stated)
//  0xFFF00093 (addi -1) -> next cycle imm 0xFFFFFFFF_FFFFFFFF, fmt I, illegal 0
//  0xFE112E23 (sw -4) -> imm 0xFFFFFFFF_FFFFFFFC fmt S; 0xFE000CE3 (beq -8) -> 0xFFFFFFFF_FFFFFFF8 fmt B
//  0x800000B7 (lui) -> 0xFFFFFFFF_80000000 fmt U; 0x0010006F (jal +2048) -> 0x800 fmt J; 0x43F0D093 (srai 63) -> 0x3F fmt SH
//  out_ready=0, stream 3 instrs -> in_ready drops after 2nd accept; release -> all 3 emerge in order, back-to-back
//  M and K full + flush, with in_valid=1 in the same cycle -> out_valid=0 next cycle, in_ready=1, input dropped
//  CNT_W=2, 5 accepted 0x00000000 words -> illegal=1 each, illegal_count saturates at 3; reset -> 0

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the ID-stage immediate generator.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_R    = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_SRL = 3'b101;

    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == FUNCT3_SLL) || (funct3 == FUNCT3_SRL);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: raw instruction -> XLEN immediate, format, illegal flag.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic signed [31:0] imm32;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];

    always_comb begin
        imm32   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                imm32 = {{20{instruction[31]}}, instruction[31:20]};
                fmt   = FMT_I;
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                if (is_shift(funct3)) begin
                    // Only the 64-bit op-imm shifts own a 6-bit shamt; the W forms stay 5-bit.
                    if (XLEN == 64 && opcode == OPC_OP_IMM)
                        imm32 = {26'b0, instruction[25:20]};
                    else
                        imm32 = {27'b0, instruction[24:20]};
                    fmt = FMT_SH;
                end else begin
                    imm32 = {{20{instruction[31]}}, instruction[31:20]};
                    fmt   = FMT_I;
                end
            end
            OPC_STORE: begin
                imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
                fmt   = FMT_S;
            end
            OPC_BRANCH: begin
                imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
                fmt   = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32 = {instruction[31:12], 12'b0};
                fmt   = FMT_U;
            end
            OPC_JAL: begin
                imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
                fmt   = FMT_J;
            end
            OPC_OP, OPC_OP_32: begin
                fmt = FMT_R;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Every format fits in 32 signed bits; the width cast sign-extends to XLEN (XLEN is 32 or 64).
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a main/skid register pair, flush and illegal counter.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_data,
    output imm_fmt_e         imm_fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instruction (instruction),
        .imm         (dec_imm),
        .fmt         (dec_fmt),
        .illegal     (dec_illegal)
    );

    logic             m_valid_reg, k_valid_reg;
    logic [XLEN-1:0]  m_imm_reg, k_imm_reg;
    imm_fmt_e         m_fmt_reg, k_fmt_reg;
    logic             m_illegal_reg, k_illegal_reg;
    logic [CNT_W-1:0] illegal_count_reg;
    logic             accept, drain;

    // in_ready depends only on the skid register, so out_ready never reaches it combinationally.
    assign in_ready = !k_valid_reg;
    assign accept   = in_valid && in_ready && !flush;
    assign drain    = m_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_reg       <= 1'b0;
            m_imm_reg         <= '0;
            m_fmt_reg         <= FMT_NONE;
            m_illegal_reg     <= 1'b0;
            k_valid_reg       <= 1'b0;
            k_imm_reg         <= '0;
            k_fmt_reg         <= FMT_NONE;
            k_illegal_reg     <= 1'b0;
            illegal_count_reg <= '0;
        end else begin
            if (flush) begin
                m_valid_reg <= 1'b0;
                k_valid_reg <= 1'b0;
            end else if (drain && k_valid_reg) begin
                // Skid entry is older than anything on the input, so it refills M first.
                m_imm_reg     <= k_imm_reg;
                m_fmt_reg     <= k_fmt_reg;
                m_illegal_reg <= k_illegal_reg;
                k_valid_reg   <= 1'b0;
            end else if (accept && (!m_valid_reg || drain)) begin
                m_valid_reg   <= 1'b1;
                m_imm_reg     <= dec_imm;
                m_fmt_reg     <= dec_fmt;
                m_illegal_reg <= dec_illegal;
            end else if (accept) begin
                k_valid_reg   <= 1'b1;
                k_imm_reg     <= dec_imm;
                k_fmt_reg     <= dec_fmt;
                k_illegal_reg <= dec_illegal;
            end else if (drain) begin
                m_valid_reg <= 1'b0;
            end

            if (accept && dec_illegal && !(&illegal_count_reg))
                illegal_count_reg <= illegal_count_reg + CNT_W'(1);
        end
    end

    assign out_valid     = m_valid_reg;
    assign imm_data      = m_imm_reg;
    assign imm_fmt       = m_fmt_reg;
    assign illegal       = m_illegal_reg;
    assign illegal_count = illegal_count_reg;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: directed vectors, queue of expected outputs, negedge monitor.
module tb_imm_gen_stage;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] instruction;
    logic        in_ready, out_valid, illegal;
    logic [63:0] imm_data;
    imm_fmt_e    imm_fmt;
    logic [15:0] illegal_count;

    logic        reset2, in_valid2, out_ready2;
    logic [31:0] instruction2;
    logic        in_ready2, out_valid2, illegal2;
    logic [63:0] imm_data2;
    imm_fmt_e    imm_fmt2;
    logic [1:0]  illegal_count2;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm_data(imm_data), .imm_fmt(imm_fmt), .illegal(illegal),
        .illegal_count(illegal_count)
    );

    imm_gen_stage #(.XLEN(64), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset2), .flush(1'b0),
        .in_valid(in_valid2), .in_ready(in_ready2), .instruction(instruction2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .imm_data(imm_data2), .imm_fmt(imm_fmt2), .illegal(illegal2),
        .illegal_count(illegal_count2)
    );

    typedef struct {
        logic [31:0] ins;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: pops one expected entry per output transfer; also checks hold-while-stalled.
    logic        hold_prev = 1'b0;
    logic        flush_prev = 1'b0;
    logic [63:0] imm_prev = '0;
    logic [2:0]  fmt_prev = '0;

    always @(negedge clk) begin
        if (!reset) begin
            if (hold_prev && !flush_prev) begin
                chk("hold_valid", {63'b0, out_valid}, 64'd1);
                chk("hold_imm", imm_data, imm_prev);
                chk("hold_fmt", {61'b0, imm_fmt}, {61'b0, fmt_prev});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", {63'b0, out_valid}, 64'd0);
                end else begin
                    vec_t e;
                    e = q.pop_front();
                    chk($sformatf("imm[%h]", e.ins), imm_data, e.imm);
                    chk($sformatf("fmt[%h]", e.ins), {61'b0, imm_fmt}, {61'b0, e.fmt});
                    chk($sformatf("ill[%h]", e.ins), {63'b0, illegal}, {63'b0, e.ill});
                end
            end
        end
        hold_prev  <= out_valid && !out_ready && !reset;
        flush_prev <= flush;
        imm_prev   <= imm_data;
        fmt_prev   <= imm_fmt;
    end

    // Holds in_valid until in_ready is seen, then pushes the expected result for that accept.
    task automatic send(input vec_t v);
        int waited;
        waited = 0;
        in_valid    = 1'b1;
        instruction = v.ins;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                chk("in_ready_timeout", {63'b0, in_ready}, 64'd1);
                break;
            end
        end
        q.push_back(v);
        if (v.ill) exp_cnt++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic [31:0] ins, input logic [63:0] imm,
                                input imm_fmt_e fmt, input logic ill);
        vec_t v;
        v.ins = ins; v.imm = imm; v.fmt = fmt; v.ill = ill;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instruction = '0;
        reset2 = 1'b1; in_valid2 = 1'b0; out_ready2 = 1'b1; instruction2 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; reset2 = 1'b0;

        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_imm", imm_data, 64'd0);
        chk("rst_fmt", {61'b0, imm_fmt}, 64'd0);
        chk("rst_illegal", {63'b0, illegal}, 64'd0);
        chk("rst_count", {48'b0, illegal_count}, 64'd0);

        tbl.push_back(mk(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I,    1'b0)); // addi -1
        tbl.push_back(mk(32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, FMT_S,    1'b0)); // sw -4
        tbl.push_back(mk(32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, FMT_B,    1'b0)); // beq -8
        tbl.push_back(mk(32'h800000B7, 64'hFFFF_FFFF_8000_0000, FMT_U,    1'b0)); // lui
        tbl.push_back(mk(32'h12345097, 64'h0000_0000_1234_5000, FMT_U,    1'b0)); // auipc
        tbl.push_back(mk(32'h0010006F, 64'h0000_0000_0000_0800, FMT_J,    1'b0)); // jal +2048
        tbl.push_back(mk(32'h43F0D093, 64'h0000_0000_0000_003F, FMT_SH,   1'b0)); // srai 63
        tbl.push_back(mk(32'h02101013, 64'h0000_0000_0000_0021, FMT_SH,   1'b0)); // slli 33
        tbl.push_back(mk(32'h0210101B, 64'h0000_0000_0000_0001, FMT_SH,   1'b0)); // slliw: 5-bit shamt
        tbl.push_back(mk(32'h8005051B, 64'hFFFF_FFFF_FFFF_F800, FMT_I,    1'b0)); // addiw -2048
        tbl.push_back(mk(32'h00853503, 64'h0000_0000_0000_0008, FMT_I,    1'b0)); // ld 8
        tbl.push_back(mk(32'h000080E7, 64'h0000_0000_0000_0000, FMT_I,    1'b0)); // jalr 0
        tbl.push_back(mk(32'h00B50533, 64'h0000_0000_0000_0000, FMT_R,    1'b0)); // add
        tbl.push_back(mk(32'h00B5053B, 64'h0000_0000_0000_0000, FMT_R,    1'b0)); // addw
        tbl.push_back(mk(32'hFFFFFFFF, 64'h0000_0000_0000_0000, FMT_NONE, 1'b1)); // bad opcode
        tbl.push_back(mk(32'h00000000, 64'h0000_0000_0000_0000, FMT_NONE, 1'b1)); // all zeros

        foreach (tbl[i]) send(tbl[i]);
        repeat (3) @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("count_after_stream", {48'b0, illegal_count}, 64'(exp_cnt));

        // Backpressure: two accepts fill M and K, third waits until release.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(tbl[0]);
        chk("bp_in_ready_after_1", {63'b0, in_ready}, 64'd1);
        send(tbl[1]);
        chk("bp_in_ready_after_2", {63'b0, in_ready}, 64'd0);
        @(negedge clk);
        chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        fork
            send(tbl[2]);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk($sformatf("b2b_valid_%0d", i), {63'b0, out_valid}, 64'd1);
                end
            end
        join
        repeat (2) @(negedge clk);
        chk("bp_drain_empty", 64'(q.size()), 64'd0);

        // Flush with M and K full and a same-cycle (illegal) input: input dropped, not counted.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(tbl[3]);
        send(tbl[4]);
        flush = 1'b1; in_valid = 1'b1; instruction = 32'h00000000;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        q.delete();
        chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
        chk("flush_count", {48'b0, illegal_count}, 64'(exp_cnt));
        @(posedge clk); #1;
        chk("flush_dropped", {63'b0, out_valid}, 64'd0);

        // Flush while M transfers: the consumer still takes that entry.
        out_ready = 1'b1;
        send(tbl[5]);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_xfer_consumed", 64'(q.size()), 64'd0);
        chk("flush_xfer_valid", {63'b0, out_valid}, 64'd0);

        // Saturating counter on the CNT_W=2 instance.
        for (int k = 1; k <= 5; k++) begin
            in_valid2 = 1'b1; instruction2 = 32'h00000000;
            @(posedge clk); #1;
            chk($sformatf("sat_count_%0d", k), {62'b0, illegal_count2}, 64'((k < 3) ? k : 3));
            chk($sformatf("sat_illegal_%0d", k), {62'b0, out_valid2, illegal2}, 64'd3);
        end
        in_valid2 = 1'b0;
        reset2 = 1'b1;
        @(posedge clk); #1;
        reset2 = 1'b0;
        chk("sat_count_reset", {62'b0, illegal_count2}, 64'd0);

        // Reset with both registers full and a simultaneous flush.
        out_ready = 1'b0;
        send(tbl[6]);
        send(tbl[7]);
        reset = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; flush = 1'b0;
        q.delete();
        chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("mid_rst_imm", imm_data, 64'd0);
        chk("mid_rst_count", {48'b0, illegal_count}, 64'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
